mux_tree_pipelined: RTL and testbench

//  Parametrised, pipelined N-to-1 selector (successor to the fixed 2/4/16-to-1 muxes).

---
 rtl/mux_tree_pipelined_pkg.sv | 30 +++
 rtl/mux_tree_stage.sv | 63 ++++++
 rtl/mux_tree_pipelined.sv | 66 ++++++
 tb/tb_mux_tree_pipelined.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_tree_pipelined_pkg.sv
// Shared constants and geometry helpers for the pipelined radix-4 select tree.
// All words of every stage are packed into one flat chain, lowest stage first.
package mux_tree_pipelined_pkg;

  function automatic int num_stages(input int sw);
    return (sw + 1) / 2;
  endfunction

  function automatic int stage_radix(input int sw, input int k);
    return (2 * k + 2 <= sw) ? 4 : 2;
  endfunction

  function automatic int radix_bits(input int radix);
    return (radix == 4) ? 2 : 1;
  endfunction

  // Candidate words entering stage k; the final output counts as one word.
  function automatic int words_at(input int sw, input int k);
    if (k >= num_stages(sw)) return 1;
    return (1 << sw) >> (2 * k);
  endfunction

  function automatic int chain_off(input int sw, input int bw, input int k);
    int off;
    off = 0;
    for (int i = 0; i < k; i++) off += words_at(sw, i) * bw;
    return off;
  endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One registered radix-2/4 reduction level of the select tree.
// Carries the full select tag and a valid bit alongside the candidates.
module mux_tree_stage
  import mux_tree_pipelined_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int IN_WORDS  = 4,
  parameter int RADIX     = 4,
  parameter int SEL_WIDTH = 2,
  parameter int SEL_LSB   = 0
) (
  input  logic                                    i_clk,
  input  logic                                    i_reset,
  input  logic                                    i_en,
  input  logic                                    i_valid,
  input  logic [SEL_WIDTH-1:0]                    i_sel,
  input  logic [IN_WORDS*BIT_WIDTH-1:0]           i_data,
  output logic                                    o_valid,
  output logic [SEL_WIDTH-1:0]                    o_sel,
  output logic [(IN_WORDS/RADIX)*BIT_WIDTH-1:0]   o_data
);

  localparam int OUT_WORDS = IN_WORDS / RADIX;
  localparam int RB        = radix_bits(RADIX);

  logic [OUT_WORDS*BIT_WIDTH-1:0] data_d, data_q;
  logic [SEL_WIDTH-1:0]           sel_d, sel_q;
  logic                           vld_d, vld_q;
  logic [RB-1:0]                  pick;

  assign pick = i_sel[SEL_LSB +: RB];

  always_comb begin
    data_d = data_q;
    sel_d  = sel_q;
    vld_d  = vld_q;
    if (i_en) begin
      vld_d = i_valid;
      sel_d = i_sel;
      for (int g = 0; g < OUT_WORDS; g++) begin
        data_d[g*BIT_WIDTH +: BIT_WIDTH] =
          i_data[(g*RADIX + int'(pick))*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      data_q <= '0;
      sel_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      sel_q  <= sel_d;
      vld_q  <= vld_d;
    end
  end

  assign o_valid = vld_q;
  assign o_sel   = sel_q;
  assign o_data  = data_q;

endmodule

// File: rtl/mux_tree_pipelined.sv
// Pipelined N-to-1 word selector with valid/ready flow control.
// Each stage resolves two select bits; a global stall freezes every stage.
module mux_tree_pipelined
  import mux_tree_pipelined_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 4,
  parameter int NUM_INPUTS = 1 << SEL_WIDTH,
  parameter int NUM_STAGES = (SEL_WIDTH + 1) / 2
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [SEL_WIDTH-1:0]            i_sel,
  input  logic [BIT_WIDTH*NUM_INPUTS-1:0] i_A,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [BIT_WIDTH-1:0]            o_B,
  output logic [SEL_WIDTH-1:0]            o_sel
);

  localparam int CHAIN_W = chain_off(SEL_WIDTH, BIT_WIDTH, NUM_STAGES + 1);

  logic [CHAIN_W-1:0]   data_c;
  logic [SEL_WIDTH-1:0] sel_c [NUM_STAGES+1];
  logic                 vld_c [NUM_STAGES+1];
  logic                 advance;

  assign advance = !vld_c[NUM_STAGES] || i_ready;

  assign data_c[NUM_INPUTS*BIT_WIDTH-1:0] = i_A;
  assign sel_c[0] = i_sel;
  assign vld_c[0] = i_valid;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int IW    = words_at(SEL_WIDTH, k);
    localparam int RX    = stage_radix(SEL_WIDTH, k);
    localparam int OFF_I = chain_off(SEL_WIDTH, BIT_WIDTH, k);
    localparam int OFF_O = chain_off(SEL_WIDTH, BIT_WIDTH, k + 1);

    mux_tree_stage #(
      .BIT_WIDTH (BIT_WIDTH),
      .IN_WORDS  (IW),
      .RADIX     (RX),
      .SEL_WIDTH (SEL_WIDTH),
      .SEL_LSB   (2 * k)
    ) u_stage (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (advance),
      .i_valid (vld_c[k]),
      .i_sel   (sel_c[k]),
      .i_data  (data_c[OFF_I +: IW*BIT_WIDTH]),
      .o_valid (vld_c[k+1]),
      .o_sel   (sel_c[k+1]),
      .o_data  (data_c[OFF_O +: (IW/RX)*BIT_WIDTH])
    );
  end

  assign o_ready = advance;
  assign o_valid = vld_c[NUM_STAGES];
  assign o_sel   = sel_c[NUM_STAGES];
  assign o_B     = data_c[CHAIN_W-1 -: BIT_WIDTH];

endmodule

// File: tb/tb_mux_tree_pipelined.sv
// Bench for mux_tree_pipelined: default, odd-width, 1-bit and random configs.
// Queue scoreboards track every accepted word through to retirement.
module tb_mux_tree_pipelined;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         v4, r4, ov4, or4;
  logic [3:0]   sel4, osel4;
  logic [255:0] a4;
  logic [15:0]  b4;

  logic         v3, r3, ov3, or3;
  logic [2:0]   sel3, osel3;
  logic [63:0]  a3;
  logic [7:0]   b3;

  logic         v1, r1, ov1, or1;
  logic [0:0]   sel1, osel1;
  logic [15:0]  a1;
  logic [7:0]   b1;

  logic          v5, r5, ov5, or5;
  logic [4:0]    sel5, osel5;
  logic [1023:0] a5;
  logic [31:0]   b5;

  mux_tree_pipelined #(.BIT_WIDTH(16), .SEL_WIDTH(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_valid(v4), .o_ready(or4),
    .i_sel(sel4), .i_A(a4), .o_valid(ov4), .i_ready(r4),
    .o_B(b4), .o_sel(osel4));

  mux_tree_pipelined #(.BIT_WIDTH(8), .SEL_WIDTH(3)) dut3 (
    .i_clk(clk), .i_reset(rst), .i_valid(v3), .o_ready(or3),
    .i_sel(sel3), .i_A(a3), .o_valid(ov3), .i_ready(r3),
    .o_B(b3), .o_sel(osel3));

  mux_tree_pipelined #(.BIT_WIDTH(8), .SEL_WIDTH(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_valid(v1), .o_ready(or1),
    .i_sel(sel1), .i_A(a1), .o_valid(ov1), .i_ready(r1),
    .o_B(b1), .o_sel(osel1));

  mux_tree_pipelined #(.BIT_WIDTH(32), .SEL_WIDTH(5)) dut5 (
    .i_clk(clk), .i_reset(rst), .i_valid(v5), .o_ready(or5),
    .i_sel(sel5), .i_A(a5), .o_valid(ov5), .i_ready(r5),
    .o_B(b5), .o_sel(osel5));

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic v, input logic [3:0] s, input logic r);
    v4 = v; sel4 = s; r4 = r;
  endtask

  typedef struct { logic [3:0] sel; logic [15:0] w; } sb4_t;
  typedef struct { logic [4:0] sel; logic [31:0] w; } sb5_t;
  sb4_t q4[$];
  sb5_t q5[$];
  int retired4 = 0;
  int retired5 = 0;

  always @(negedge clk) begin : mon4
    sb4_t e;
    if (!rst) begin
      if (ov4 && r4) begin
        if (q4.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb4_unexpected: o_B=%0h o_sel=%0d, want no output",
                   b4, osel4);
        end else begin
          e = q4.pop_front();
          chk("sb4_data", b4, e.w);
          chk("sb4_sel", osel4, e.sel);
          retired4++;
        end
      end
      if (v4 && or4) q4.push_back('{sel: sel4, w: a4[sel4*16 +: 16]});
    end
  end

  always @(negedge clk) begin : mon5
    sb5_t e;
    if (!rst) begin
      if (ov5 && r5) begin
        if (q5.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb5_unexpected: o_B=%0h o_sel=%0d, want no output",
                   b5, osel5);
        end else begin
          e = q5.pop_front();
          chk("sb5_data", b5, e.w);
          chk("sb5_sel", osel5, e.sel);
          retired5++;
        end
      end
      if (v5 && or5) q5.push_back('{sel: sel5, w: a5[sel5*32 +: 32]});
    end
  end

  typedef struct { logic [3:0] sel; logic [15:0] exp; } vec_t;
  vec_t tab[16];
  logic pat[4];
  logic [3:0] psel[4];
  int base;
  logic exp_v;

  initial begin
    for (int i = 0; i < 16; i++) begin
      tab[i].sel = 4'(i);
      tab[i].exp = 16'hA000 + 16'(i);
    end
    pat  = '{1'b1, 1'b0, 1'b1, 1'b1};
    psel = '{4'd1, 4'd2, 4'd9, 4'd15};
    for (int j = 0; j < 16; j++) a4[j*16 +: 16] = 16'hA000 + 16'(j);
    for (int j = 0; j < 8; j++) a3[j*8 +: 8] = 8'h10 + 8'(j);
    a1 = {8'hC3, 8'h5A};
    a5 = '0;
    rst = 1'b1;
    drive4(0, 0, 1);
    v3 = 0; sel3 = 0; r3 = 1;
    v1 = 0; sel1 = 0; r1 = 1;
    v5 = 0; sel5 = 0; r5 = 1;

    #1;
    chk("rst_ovalid", ov4, 0);
    chk("rst_ob", b4, 0);
    chk("rst_osel", osel4, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_oready", or4, 1);

    // Reset asserted between edges while two words are in flight
    drive4(1, 5, 1); step();
    drive4(1, 6, 1); step();
    chk("midrst_pre_valid", ov4, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ovalid", ov4, 0);
    chk("midrst_ob", b4, 0);
    chk("midrst_osel", osel4, 0);
    q4.delete();
    drive4(0, 0, 1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_idle", ov4, 0);
    end
    chk("midrst_oready", or4, 1);

    // Back-to-back sweep of every select value
    for (int i = 0; i < 16; i++) begin
      drive4(1, tab[i].sel, 1);
      step();
      if (i == 0) begin
        chk("sweep_lat_early", ov4, 0);
      end else begin
        chk("sweep_ovalid", ov4, 1);
        chk("sweep_ob", b4, tab[i-1].exp);
      end
    end
    drive4(0, 0, 1); step();
    chk("sweep_last_ob", b4, tab[15].exp);
    step();
    chk("sweep_drained", ov4, 0);

    // Backpressure holds output and blocks new accepts
    drive4(1, 3, 1); step();
    drive4(1, 7, 1); step();
    chk("bp_rise", ov4, 1);
    base = retired4;
    drive4(1, 11, 0);
    for (int i = 0; i < 4; i++) begin
      #0;
      chk("bp_hold_ob", b4, 16'hA003);
      chk("bp_hold_osel", osel4, 3);
      chk("bp_oready", or4, 0);
      step();
    end
    chk("bp_hold_valid", ov4, 1);
    drive4(1, 11, 1); step();
    drive4(0, 0, 1);
    repeat (3) step();
    chk("bp_count", retired4 - base, 3);
    chk("bp_queue", q4.size(), 0);

    // Bubble pattern with same-cycle accept and retire
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive4(pat[i], psel[i], 1);
      else drive4(0, 0, 1);
      #0;
      chk("bub_oready", or4, 1);
      step();
      exp_v = (i >= 1 && i <= 4) ? pat[i-1] : 1'b0;
      chk("bub_ovalid", ov4, exp_v);
    end
    chk("bub_queue", q4.size(), 0);

    // Odd select width: 4:1 then 2:1
    v3 = 1; sel3 = 7; step();
    chk("odd_lat_early", ov3, 0);
    sel3 = 0; step();
    chk("odd_ovalid", ov3, 1);
    chk("odd_ob_top", b3, 8'h17);
    chk("odd_osel_top", osel3, 7);
    v3 = 0; step();
    chk("odd_ob_bottom", b3, 8'h10);
    chk("odd_osel_bottom", osel3, 0);

    // Single 2:1 stage, latency one
    v1 = 1; sel1 = 1; step();
    chk("w1_ovalid", ov1, 1);
    chk("w1_ob_top", b1, 8'hC3);
    chk("w1_osel", osel1, 1);
    sel1 = 0; step();
    chk("w1_ob_bottom", b1, 8'h5A);
    v1 = 0; step();
    chk("w1_drained", ov1, 0);

    // Random traffic on the 32-word configuration
    for (int c = 0; c < 10000; c++) begin
      for (int j = 0; j < 32; j++) a5[j*32 +: 32] = $urandom;
      sel5 = 5'($urandom_range(0, 31));
      v5 = ($urandom_range(0, 3) != 0);
      r5 = ($urandom_range(0, 3) != 0);
      step();
    end
    v5 = 0; r5 = 1;
    repeat (5) step();
    chk("rnd_queue", q5.size(), 0);
    chk("rnd_active", (retired5 > 1000) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
